// File: rtl/pixel_position_counter.sv
// Raster position generator: derives pixel column/row coordinates from
// HSYNC/VSYNC timing with an internal clock prescaler, and produces
// active-region and line/frame event strobes for the fetch and colour logic.
module pixel_position_counter #(
    parameter int PRESCALE = 8,   // clock cycles per pixel, >= 2
    parameter int H_BITS   = 6,   // width of Hcount
    parameter int V_BITS   = 6,   // width of Vcount
    parameter int H_ACTIVE = 64,  // pixels per line, <= 2**H_BITS
    parameter int V_ACTIVE = 64,  // lines per frame, <= 2**V_BITS
    parameter int SYNC_LOW = 1,   // 1 = syncs active-low, 0 = active-high
    parameter int WRAP     = 0    // 1 = Hcount wraps to 0 after last pixel
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              HSYNC,
    input  logic              VSYNC,
    output logic [H_BITS-1:0] Hcount,
    output logic [V_BITS-1:0] Vcount,
    output logic              pixel_strobe,
    output logic              active,
    output logic              line_done,
    output logic              frame_done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [H_BITS-1:0] H_LAST  = H_BITS'(H_ACTIVE - 1);
    localparam logic [V_BITS-1:0] V_LAST  = V_BITS'(V_ACTIVE - 1);

    logic [PS_W-1:0]   prescale_reg;
    logic [H_BITS-1:0] hcount_reg;
    logic [V_BITS-1:0] vcount_reg;
    logic              pixel_strobe_reg;
    logic              line_done_reg;
    logic              frame_done_reg;
    logic              frame_active_reg;
    logic              line_active_reg;
    logic              line_seen_reg;
    logic              hs_prev_reg;

    logic hs_act;
    logic vs_act;
    logic sync_act;
    logic pixel_tick;
    logic line_edge;

    // Polarity-corrected syncs; inputs are already in this clock domain.
    assign hs_act   = (SYNC_LOW != 0) ? ~HSYNC : HSYNC;
    assign vs_act   = (SYNC_LOW != 0) ? ~VSYNC : VSYNC;
    assign sync_act = hs_act | vs_act;

    // A pixel advances at the end of each prescaler period, only inside a live line.
    assign pixel_tick = (prescale_reg == PS_LAST) & line_active_reg &
                        frame_active_reg & ~sync_act;

    // A line only counts if at least one pixel was emitted since the last
    // line end, so blank back-porch lines are skipped. VSYNC dominates.
    assign line_edge = hs_act & ~hs_prev_reg & ~vs_act &
                       frame_active_reg & line_seen_reg;

    // Prescaler: held at zero during sync so every line starts phase-aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_reg <= '0;
        end else if (sync_act) begin
            prescale_reg <= '0;
        end else if (prescale_reg == PS_LAST) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
        end
    end

    // Column counter and end-of-line latch; sync clear wins over a tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_reg      <= '0;
            line_active_reg <= 1'b1;
        end else if (sync_act) begin
            hcount_reg      <= '0;
            line_active_reg <= 1'b1;
        end else if (pixel_tick) begin
            if (hcount_reg != H_LAST) begin
                hcount_reg <= hcount_reg + 1'b1;
            end else if (WRAP != 0) begin
                hcount_reg <= '0;
            end else begin
                line_active_reg <= 1'b0;
            end
        end
    end

    // Pixel strobe lines up with the cycle the new column value appears.
    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_strobe_reg <= 1'b0;
        end else begin
            pixel_strobe_reg <= pixel_tick;
        end
    end

    // Tracks whether the current line has produced any pixel yet.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_seen_reg <= 1'b0;
        end else if (vs_act || line_edge) begin
            line_seen_reg <= 1'b0;
        end else if (pixel_tick) begin
            line_seen_reg <= 1'b1;
        end
    end

    // HSYNC edge history, stored as the polarity-corrected level.
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_prev_reg <= 1'b0;
        end else begin
            hs_prev_reg <= hs_act;
        end
    end

    // Row counter and frame state; VSYNC restarts the frame, and an early
    // VSYNC simply aborts the running frame without any done strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            vcount_reg       <= '0;
            frame_active_reg <= 1'b0;
        end else if (vs_act) begin
            vcount_reg       <= '0;
            frame_active_reg <= 1'b1;
        end else if (line_edge) begin
            if (vcount_reg != V_LAST) begin
                vcount_reg <= vcount_reg + 1'b1;
            end else begin
                frame_active_reg <= 1'b0;
            end
        end
    end

    // Line/frame event strobes, one cycle each, registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            line_done_reg  <= line_edge;
            frame_done_reg <= line_edge & (vcount_reg == V_LAST);
        end
    end

    assign Hcount       = hcount_reg;
    assign Vcount       = vcount_reg;
    assign pixel_strobe = pixel_strobe_reg;
    assign line_done    = line_done_reg;
    assign frame_done   = frame_done_reg;
    assign active       = line_active_reg & frame_active_reg & ~sync_act;

endmodule

// File: tb/tb_pixel_position_counter.sv
// Directed bench for pixel_position_counter: three instances share the
// stimulus (defaults; 4x3 non-wrapping; 4x3 wrapping) and are checked
// against hand-computed expectations. Syncs are active-low.
module tb_pixel_position_counter;

    logic clock = 1'b0;
    logic reset;
    logic HSYNC;
    logic VSYNC;

    logic [5:0] hc0, vc0, hc1, vc1, hc2, vc2;
    logic ps0, act0, ld0, fd0;
    logic ps1, act1, ld1, fd1;
    logic ps2, act2, ld2, fd2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pixel_position_counter dut0 (
        .clock(clock), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .Hcount(hc0), .Vcount(vc0), .pixel_strobe(ps0), .active(act0),
        .line_done(ld0), .frame_done(fd0)
    );

    pixel_position_counter #(.H_ACTIVE(4), .V_ACTIVE(3), .WRAP(0)) dut1 (
        .clock(clock), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .Hcount(hc1), .Vcount(vc1), .pixel_strobe(ps1), .active(act1),
        .line_done(ld1), .frame_done(fd1)
    );

    pixel_position_counter #(.H_ACTIVE(4), .V_ACTIVE(3), .WRAP(1)) dut2 (
        .clock(clock), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .Hcount(hc2), .Vcount(vc2), .pixel_strobe(ps2), .active(act2),
        .line_done(ld2), .frame_done(fd2)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hsync_edge();
        HSYNC = 1'b0;
        tick();
    endtask

    task automatic hsync_end();
        tick();
        HSYNC = 1'b1;
    endtask

    task automatic vsync_pulse();
        VSYNC = 1'b0;
        run(3);
        VSYNC = 1'b1;
    endtask

    initial begin
        int s0;
        int s1;
        reset = 1'b1;
        HSYNC = 1'b1;
        VSYNC = 1'b1;

        // Reset state
        run(2);
        check_eq("rst_hcount", hc0, 0);
        check_eq("rst_vcount", vc0, 0);
        check_eq("rst_strobe", ps0, 0);
        check_eq("rst_active", act0, 0);
        check_eq("rst_line_done", ld0, 0);
        check_eq("rst_frame_done", fd0, 0);
        $display("reset applied: Hcount=%0d Vcount=%0d active=%0d", hc0, vc0, act0);
        reset = 1'b0;

        // No counting before the first VSYNC
        run(10);
        check_eq("prevs_hcount", hc0, 0);
        check_eq("prevs_active", act0, 0);
        $display("idle before VSYNC: Hcount=%0d active=%0d", hc0, act0);

        // Frame start, then 40 clocks without HSYNC
        vsync_pulse();
        #1;
        check_eq("vs_rel_active", act0, 1);
        check_eq("vs_rel_hcount", hc0, 0);
        s0 = 0;
        s1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check_eq($sformatf("d0_strobe[%0d]", i), ps0, int'(i % 8 == 0));
            check_eq($sformatf("d0_hcount[%0d]", i), hc0, i / 8);
            check_eq($sformatf("d1_hcount[%0d]", i), hc1, (i / 8 > 3) ? 3 : i / 8);
            check_eq($sformatf("d1_active[%0d]", i), act1, int'(i < 32));
            check_eq($sformatf("d2_hcount[%0d]", i), hc2, (i / 8) % 4);
            if (ps0) s0++;
            if (ps1) s1++;
        end
        check_eq("d0_strobes", s0, 5);
        check_eq("d1_strobes", s1, 4);
        check_eq("d0_active_midline", act0, 1);
        $display("line 0: d0 Hcount=%0d strobes=%0d, d1 Hcount=%0d strobes=%0d, d2 Hcount=%0d",
                 hc0, s0, hc1, s1, hc2);

        // Three lines on the 3-line instances
        for (int l = 1; l <= 3; l++) begin
            hsync_edge();
            check_eq($sformatf("d0_ld[%0d]", l), ld0, 1);
            check_eq($sformatf("d0_vc[%0d]", l), vc0, l);
            check_eq($sformatf("d0_fd[%0d]", l), fd0, 0);
            check_eq($sformatf("d0_hc_clr[%0d]", l), hc0, 0);
            check_eq($sformatf("d1_ld[%0d]", l), ld1, 1);
            check_eq($sformatf("d1_vc[%0d]", l), vc1, (l > 2) ? 2 : l);
            check_eq($sformatf("d1_fd[%0d]", l), fd1, int'(l == 3));
            check_eq($sformatf("d1_act_sync[%0d]", l), act1, 0);
            $display("line end %0d: d0 Vcount=%0d line_done=%0d, d1 Vcount=%0d line_done=%0d frame_done=%0d",
                     l, vc0, ld0, vc1, ld1, fd1);
            hsync_end();
            check_eq($sformatf("d0_ld_off[%0d]", l), ld0, 0);
            check_eq($sformatf("d1_ld_off[%0d]", l), ld1, 0);
            check_eq($sformatf("d1_fd_off[%0d]", l), fd1, 0);
            if (l < 3) run(40);
        end

        // Back-to-back HSYNC with no pixel in between is ignored
        tick();
        hsync_edge();
        check_eq("blank_ld", ld0, 0);
        check_eq("blank_vc", vc0, 3);
        $display("blank line: d0 Vcount=%0d line_done=%0d", vc0, ld0);
        hsync_end();

        // Finished frame stays inactive until the next VSYNC
        s1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ps1) s1++;
            check_eq($sformatf("d1_post_act[%0d]", i), act1, 0);
        end
        check_eq("d1_post_strobes", s1, 0);
        check_eq("d1_post_hcount", hc1, 0);
        check_eq("d0_after_blank_hc", hc0, 5);
        $display("after frame: d1 active=%0d strobes=%0d, d0 Hcount=%0d", act1, s1, hc0);

        // New frame, two lines, then VSYNC and HSYNC together at Vcount=2
        vsync_pulse();
        check_eq("vs_vc0", vc0, 0);
        check_eq("vs_vc1", vc1, 0);
        check_eq("vs_ld0", ld0, 0);
        for (int l = 1; l <= 2; l++) begin
            run(40);
            hsync_edge();
            hsync_end();
        end
        run(40);
        check_eq("pre_both_vc0", vc0, 2);
        check_eq("pre_both_vc1", vc1, 2);
        VSYNC = 1'b0;
        HSYNC = 1'b0;
        tick();
        check_eq("both_vc0", vc0, 0);
        check_eq("both_ld0", ld0, 0);
        check_eq("both_fd0", fd0, 0);
        check_eq("both_vc1", vc1, 0);
        check_eq("both_ld1", ld1, 0);
        check_eq("both_fd1", fd1, 0);
        $display("vsync+hsync: d0 Vcount=%0d line_done=%0d, d1 Vcount=%0d frame_done=%0d",
                 vc0, ld0, vc1, fd1);
        tick();
        VSYNC = 1'b1;
        HSYNC = 1'b1;

        // Reach Hcount=5, Vcount=7 then reset mid-line
        for (int l = 1; l <= 7; l++) begin
            run(40);
            hsync_edge();
            hsync_end();
        end
        run(40);
        check_eq("pre_rst_hc", hc0, 5);
        check_eq("pre_rst_vc", vc0, 7);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_hc", hc0, 0);
        check_eq("mid_rst_vc", vc0, 0);
        check_eq("mid_rst_strobe", ps0, 0);
        check_eq("mid_rst_active", act0, 0);
        check_eq("mid_rst_ld", ld0, 0);
        check_eq("mid_rst_fd", fd0, 0);
        $display("mid-line reset: Hcount=%0d Vcount=%0d active=%0d", hc0, vc0, act0);
        reset = 1'b0;
        run(40);
        check_eq("post_rst_hc", hc0, 0);
        check_eq("post_rst_active", act0, 0);
        vsync_pulse();
        run(16);
        check_eq("resume_hc", hc0, 2);
        check_eq("resume_active", act0, 1);
        $display("resume after VSYNC: Hcount=%0d active=%0d", hc0, act0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_position_counter.md
Name: pixel_position_counter

Overview:
Parametrised raster position generator for the display datapath. It replaces the fixed divide-by-8 column counter, which was driven by an external phase count, with an internal clock prescaler. It produces both the column (Hcount) and row (Vcount) coordinates from the HSYNC/VSYNC timing, along with active-region and event strobes for the pixel fetch and colour logic downstream.

Parameters:
PRESCALE, 8, clock cycles per pixel (>=2)
H_BITS, 6, width of Hcount
V_BITS, 6, width of Vcount
H_ACTIVE, 64, pixels per line (<= 2**H_BITS)
V_ACTIVE, 64, lines per frame (<= 2**V_BITS)
SYNC_LOW, 1, 1 = syncs active-low, 0 = active-high
WRAP, 0, 0 = Hcount stops after last pixel; 1 = Hcount wraps to 0 and keeps counting

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
HSYNC  input  1  line sync, same clock domain, polarity per SYNC_LOW
VSYNC  input  1  frame sync, same clock domain, polarity per SYNC_LOW
Hcount  output  H_BITS  current pixel column
Vcount  output  V_BITS  current row
pixel_strobe  output  1  one-cycle pulse coincident with each new Hcount value
active  output  1  high while the position is inside the visible region
line_done  output  1  one-cycle pulse at each qualifying line end
frame_done  output  1  one-cycle pulse after the last line of the frame

Behaviour:
- Reset (synchronous, active-high): Hcount=0, Vcount=0, prescaler=0, pixel_strobe=0, line_done=0, frame_done=0, frame_active=0, line_active=1, line_seen=0, hs_prev=vs_prev=inactive.
- hs_act and vs_act are the polarity-corrected HSYNC and VSYNC. They are used directly, with no synchroniser.
- frame_active=0 after reset. No counting occurs until the first VSYNC assertion.
- Prescaler (width clog2(PRESCALE)):
  - Cleared while hs_act or vs_act.
  - Otherwise it increments 0..PRESCALE-1 and wraps.
- pixel_tick = (prescaler==PRESCALE-1) & line_active & frame_active & ~hs_act & ~vs_act.
- On pixel_tick, Hcount advances:
  - Hcount < H_ACTIVE-1: Hcount+1.
  - Hcount == H_ACTIVE-1 and WRAP=0: Hcount holds and line_active<=0.
  - Hcount == H_ACTIVE-1 and WRAP=1: Hcount<=0 and line_active stays 1.
- pixel_strobe is registered from pixel_tick. It is high in the cycle the new Hcount value first appears, including the WRAP=0 final tick where Hcount holds.
- While hs_act or vs_act: Hcount<=0 and line_active<=1. Sync clear dominates a simultaneous tick.
- line_seen is set by any pixel_tick. It is cleared by a qualifying HSYNC edge and by vs_act.
- Qualifying HSYNC edge: hs_act & ~hs_prev & ~vs_act & frame_active & line_seen. On such an edge:
  - line_done pulses for 1 cycle (registered).
  - If Vcount < V_ACTIVE-1: Vcount+1.
  - Otherwise: Vcount holds, frame_active<=0, and frame_done pulses for 1 cycle in the same cycle as line_done.
- An HSYNC edge with no pixel_tick since the last edge is ignored: no Vcount change and no line_done. Back-porch blank lines therefore do not count.
- While vs_act: Vcount<=0, frame_active<=1, line_seen<=0, and no line_done or frame_done.
  - VSYNC dominates a simultaneous HSYNC edge.
  - A VSYNC arriving before V_ACTIVE lines complete aborts the frame silently.
- active (combinational) = line_active & frame_active & ~hs_act & ~vs_act.
- Vcount and Hcount never exceed V_ACTIVE-1 and H_ACTIVE-1.
- reset asserted mid-frame returns all state to reset values on the next edge.

Test Plan:
- Defaults, reset then VSYNC low 3 cycles then high, HSYNC high → Hcount steps 0,1,2… every 8 clocks; pixel_strobe pulses every 8th cycle; active=1.
- H_ACTIVE=4, WRAP=0, 40 clocks without HSYNC → Hcount stops at 3 after 32 clocks; active drops; exactly 4 strobes (0→1, 1→2, 2→3, hold). WRAP=1: Hcount sequence 0,1,2,3,0,1.
- V_ACTIVE=3, HSYNC low 2 cycles after each line → Vcount 0→1→2; line_done ×3; frame_done with the 3rd line_done; active stays 0 until next VSYNC.
- Two HSYNC pulses back-to-back with no pixel between them → second pulse produces no line_done and no Vcount change.
- VSYNC and HSYNC asserted in the same cycle with Vcount=2 → Vcount=0, line_done=0, frame_done=0.
- reset pulsed mid-line at Hcount=5, Vcount=7 → next cycle all outputs 0; counting resumes only after the next VSYNC.
